jtag_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller that sequences JTAG access to the tile's configuration and datapath.
- Pins (tck, tms, tdi) are oversampled in the system clock domain; no second clock.
- Runs the 16-state TAP FSM with a 4-bit IR, 32-bit IDCODE DR, 1-bit BYPASS DR and an 8-bit USER DR.
- The USER DR drives a configuration register consumed by the downstream datapath.

---
 rtl/jtag_pkg.sv | 47 ++++
 rtl/jtag_sync.sv | 51 +++++
 rtl/jtag_tap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP encodings, instruction opcodes and data-register selection.
package jtag_pkg;

    localparam int unsigned IR_WIDTH     = 4;
    localparam int unsigned IDCODE_WIDTH = 32;

    // TAP states, encoded as in the usual 1149.1 reference numbering
    typedef enum logic [3:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = 4'h1;
    localparam logic [IR_WIDTH-1:0] IR_USER   = 4'h8;
    localparam logic [IR_WIDTH-1:0] IR_BYPASS = 4'hF;

    // Which data register sits between TDI and TDO
    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    // Unknown opcodes fall back to BYPASS so the chain length stays defined
    function automatic dr_sel_t decode_ir(input logic [IR_WIDTH-1:0] code);
        case (code)
            IR_IDCODE: return DR_IDCODE;
            IR_USER:   return DR_USER;
            default:   return DR_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_sync.sv
// Oversamples the JTAG pins into clk and flags TCK edges aligned with TMS/TDI.
module jtag_sync
    import jtag_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic                   tck_prev;

    // Synchronizer chains, previous-tck flop and registered edge strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
            tck_rise <= 1'b0;
            tck_fall <= 1'b0;
            tms_s    <= 1'b0;
            tdi_s    <= 1'b0;
        end else begin
            tck_sync[0] <= tck;
            tms_sync[0] <= tms;
            tdi_sync[0] <= tdi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                tck_sync[i] <= tck_sync[i-1];
                tms_sync[i] <= tms_sync[i-1];
                tdi_sync[i] <= tdi_sync[i-1];
            end
            tck_prev <= tck_sync[SYNC_STAGES-1];
            tck_rise <= tck_sync[SYNC_STAGES-1] & ~tck_prev;
            tck_fall <= ~tck_sync[SYNC_STAGES-1] & tck_prev;
            tms_s    <= tms_sync[SYNC_STAGES-1];
            tdi_s    <= tdi_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: 16-state FSM, 4-bit IR, IDCODE/BYPASS/USER data registers.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter logic [IDCODE_WIDTH-1:0] IDCODE_VAL  = 32'h1000_563F,
    parameter int unsigned             USER_WIDTH  = 8,
    parameter int unsigned             SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tck,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_oe,
    output logic [USER_WIDTH-1:0] user_reg,
    output logic                  user_update,
    output logic [3:0]            tap_state
);

    logic tck_rise;
    logic tck_fall;
    logic tms_s;
    logic tdi_s;

    tap_state_t state_q;
    tap_state_t state_d;

    logic [IR_WIDTH-1:0]     ir;
    logic [IR_WIDTH-1:0]     ir_shift;
    logic [IDCODE_WIDTH-1:0] idcode_shift;
    logic                    bypass_shift;
    logic [USER_WIDTH-1:0]   user_shift;
    dr_sel_t                 dr_sel;
    logic                    dr_lsb;

    jtag_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    assign tap_state = state_q;

    // TAP state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: standard TMS-driven walk, only on a TCK rising edge
    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TAP_TLR:      state_d = tms_s ? TAP_TLR    : TAP_RTI;
                TAP_RTI:      state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_DR:   state_d = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
                TAP_CAP_DR:   state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
                TAP_SH_DR:    state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
                TAP_EX1_DR:   state_d = tms_s ? TAP_UPD_DR : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_d = tms_s ? TAP_EX2_DR : TAP_PAUSE_DR;
                TAP_EX2_DR:   state_d = tms_s ? TAP_UPD_DR : TAP_SH_DR;
                TAP_UPD_DR:   state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_IR:   state_d = tms_s ? TAP_TLR    : TAP_CAP_IR;
                TAP_CAP_IR:   state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
                TAP_SH_IR:    state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
                TAP_EX1_IR:   state_d = tms_s ? TAP_UPD_IR : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_d = tms_s ? TAP_EX2_IR : TAP_PAUSE_IR;
                TAP_EX2_IR:   state_d = tms_s ? TAP_UPD_IR : TAP_SH_IR;
                TAP_UPD_IR:   state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
                default:      state_d = TAP_TLR;
            endcase
        end
    end

    // Instruction decode and the bit presented to TDO from the selected DR
    always_comb begin
        dr_sel = decode_ir(ir);
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_shift[0];
            DR_USER:   dr_lsb = user_shift[0];
            default:   dr_lsb = bypass_shift;
        endcase
    end

    // Capture and shift on TCK rise, keyed on the state before the transition
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_shift     <= '0;
            idcode_shift <= '0;
            bypass_shift <= 1'b0;
            user_shift   <= '0;
        end else if (tck_rise) begin
            case (state_q)
                TAP_CAP_IR: ir_shift <= IR_WIDTH'(1);
                TAP_SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
                TAP_CAP_DR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_shift <= IDCODE_VAL;
                        DR_USER:   user_shift   <= user_reg;
                        default:   bypass_shift <= 1'b0;
                    endcase
                end
                TAP_SH_DR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_shift <= {tdi_s, idcode_shift[IDCODE_WIDTH-1:1]};
                        DR_USER:   user_shift   <= {tdi_s, user_shift[USER_WIDTH-1:1]};
                        default:   bypass_shift <= tdi_s;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // TDO drive, IR/USER updates and TLR instruction reset on TCK fall
    always_ff @(posedge clk) begin
        if (rst) begin
            tdo         <= 1'b0;
            tdo_oe      <= 1'b0;
            ir          <= IR_IDCODE;
            user_reg    <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (tck_fall) begin
                tdo_oe <= 1'b0;
                case (state_q)
                    TAP_SH_IR: begin
                        tdo    <= ir_shift[0];
                        tdo_oe <= 1'b1;
                    end
                    TAP_SH_DR: begin
                        tdo    <= dr_lsb;
                        tdo_oe <= 1'b1;
                    end
                    TAP_UPD_IR: ir <= ir_shift;
                    TAP_UPD_DR: begin
                        if (dr_sel == DR_USER) begin
                            user_reg    <= user_shift;
                            user_update <= 1'b1;
                        end
                    end
                    TAP_TLR: ir <= IR_IDCODE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl with a TDO expectation queue.
module tb_jtag_tap_ctrl;

    localparam int unsigned PH = 4;

    logic       clk;
    logic       rst;
    logic       tck;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_oe;
    logic [7:0] user_reg;
    logic       user_update;
    logic [3:0] tap_state;

    int   checks   = 0;
    int   failures = 0;
    int   upd_count = 0;
    logic tdo_seen;
    logic oe_seen;
    logic exp_q[$];

    jtag_tap_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tck         (tck),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_oe      (tdo_oe),
        .user_reg    (user_reg),
        .user_update (user_update),
        .tap_state   (tap_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count clk cycles with user_update high
    always @(negedge clk) begin
        if (user_update === 1'b1) upd_count = upd_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One TCK period; TDO/TDO_OE sampled just before the rising edge
    task automatic pulse(input logic m, input logic d);
        tms = m;
        tdi = d;
        repeat (PH) @(negedge clk);
        tdo_seen = tdo;
        oe_seen  = tdo_oe;
        tck = 1'b1;
        repeat (PH) @(negedge clk);
        tck = 1'b0;
    endtask

    task automatic settle();
        repeat (PH) @(negedge clk);
    endtask

    task automatic goto_shdr();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
    endtask

    task automatic goto_shir();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
    endtask

    task automatic push_bits(input int n, input logic [31:0] val);
        logic [31:0] v;
        v = val;
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    // Shift n bits LSB first, leaving on the last bit, and score TDO per bit
    task automatic shift_bits(input string tag, input int n, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        d = data;
        for (int i = 0; i < n; i++) begin
            pulse((i == n - 1) ? 1'b1 : 1'b0, d[i]);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s scoreboard empty observed=%b", tag, tdo_seen);
            end else begin
                e = exp_q.pop_front();
                check(tag, 32'(tdo_seen), 32'(e));
            end
            check({tag, "_oe"}, 32'(oe_seen), 32'd1);
        end
    endtask

    task automatic exit_update();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        settle();
    endtask

    int base;

    initial begin
        rst = 1'b1;
        tck = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_state",  32'(tap_state),   32'hF);
        check("rst_oe",     32'(tdo_oe),      32'd0);
        check("rst_tdo",    32'(tdo),         32'd0);
        check("rst_user",   32'(user_reg),    32'h00);
        check("rst_update", 32'(user_update), 32'd0);

        // IDCODE readout straight from TLR
        pulse(1'b0, 1'b0);
        settle();
        check("rti_state", 32'(tap_state), 32'hC);
        goto_shdr();
        settle();
        check("shdr_state", 32'(tap_state), 32'h2);
        push_bits(32, 32'h1000_563F);
        shift_bits("idcode", 32, 32'h0);
        exit_update();
        check("idcode_exit_state", 32'(tap_state), 32'hC);
        check("idcode_exit_oe",    32'(tdo_oe),    32'd0);

        // IR capture value and load USER
        goto_shir();
        push_bits(4, 32'h1);
        shift_bits("ir_cap_user", 4, 32'h8);
        exit_update();

        // USER write with one-clk update pulse, then read-back
        base = upd_count;
        goto_shdr();
        push_bits(8, 32'h00);
        shift_bits("user_first", 8, 32'hA5);
        exit_update();
        check("user_reg_a5",  32'(user_reg),        32'hA5);
        check("user_upd_one", 32'(upd_count - base), 32'd1);

        base = upd_count;
        goto_shdr();
        push_bits(8, 32'hA5);
        shift_bits("user_readback", 8, 32'h3C);
        exit_update();
        check("user_reg_3c",  32'(user_reg),        32'h3C);
        check("user_upd_two", 32'(upd_count - base), 32'd1);

        // BYPASS via explicit opcode: one-TCK delay, first bit 0
        goto_shir();
        push_bits(4, 32'h1);
        shift_bits("ir_cap_byp", 4, 32'hF);
        exit_update();
        base = upd_count;
        goto_shdr();
        push_bits(4, 32'hA);
        shift_bits("bypass_f", 4, 32'hD);
        exit_update();

        // Unknown opcode also behaves as BYPASS
        goto_shir();
        push_bits(4, 32'h1);
        shift_bits("ir_cap_3", 4, 32'h3);
        exit_update();
        goto_shdr();
        push_bits(4, 32'hA);
        shift_bits("bypass_3", 4, 32'hD);
        exit_update();
        check("bypass_no_upd",  32'(upd_count - base), 32'd0);
        check("bypass_user_kept", 32'(user_reg),       32'h3C);

        // Five TMS=1 clocks from ShDR reach TLR; IR returns to IDCODE
        goto_shdr();
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        settle();
        check("tms5_tlr",       32'(tap_state), 32'hF);
        check("tlr_keeps_user", 32'(user_reg),  32'h3C);
        pulse(1'b0, 1'b0);
        goto_shdr();
        push_bits(32, 32'h1000_563F);
        shift_bits("idcode_after_tlr", 32, 32'h0);
        exit_update();

        // Reset in the middle of an IR shift
        goto_shir();
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        settle();
        check("mid_shir_state", 32'(tap_state), 32'hA);
        check("mid_shir_oe",    32'(tdo_oe),    32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state",  32'(tap_state),   32'hF);
        check("midrst_tdo",    32'(tdo),         32'd0);
        check("midrst_oe",     32'(tdo_oe),      32'd0);
        check("midrst_user",   32'(user_reg),    32'h00);
        check("midrst_update", 32'(user_update), 32'd0);

        // TCK activity while reset is held is ignored
        tms = 1'b0;
        tck = 1'b1;
        repeat (6) @(negedge clk);
        tck = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        settle();
        check("rst_tck_ignored", 32'(tap_state), 32'hF);

        // Recovery after reset: IR is IDCODE again
        pulse(1'b0, 1'b0);
        goto_shdr();
        push_bits(32, 32'h1000_563F);
        shift_bits("idcode_after_rst", 32, 32'h0);
        exit_update();
        check("final_state", 32'(tap_state), 32'hC);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
